alu_seq: RTL

//   Sequential ALU stage downstream of the register file. On START it captures the

---
 rtl/alu_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU stage: single-cycle logic/add ops, bit-serial shifts and
// shift-add multiply, with a registered result bus and {Z,N,C,V} flags.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             ck,
  input  logic             res,
  input  logic [WIDTH-1:0] Lbus,
  input  logic [WIDTH-1:0] Rbus,
  input  logic [3:0]       FUNC,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Obus,
  output logic [3:0]       FLAGS
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_AND = 4'd2, F_OR  = 4'd3,
                         F_XOR = 4'd4, F_NOT = 4'd5, F_SHL = 4'd6, F_SHR = 4'd7,
                         F_MUL = 4'd8, F_PASS = 4'd9;

  state_t           state;
  logic [WIDTH-1:0] a, b, acc;
  logic [3:0]       f;
  logic [SHW:0]     cnt;
  logic             c;

  // Single-cycle result straight from the read buses, used at accept.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r1;
  logic             c1, v1, multi;

  always_comb begin
    sum = '0;
    r1  = '0;
    c1  = 1'b0;
    v1  = 1'b0;
    case (FUNC)
      F_ADD: begin
        sum = {1'b0, Lbus} + {1'b0, Rbus};
        r1  = sum[WIDTH-1:0];
        c1  = sum[WIDTH];
        v1  = (Lbus[WIDTH-1] == Rbus[WIDTH-1]) && (r1[WIDTH-1] != Lbus[WIDTH-1]);
      end
      F_SUB: begin
        sum = {1'b0, Lbus} - {1'b0, Rbus};
        r1  = sum[WIDTH-1:0];
        c1  = sum[WIDTH];
        v1  = (Lbus[WIDTH-1] != Rbus[WIDTH-1]) && (r1[WIDTH-1] != Lbus[WIDTH-1]);
      end
      F_AND:  r1 = Lbus & Rbus;
      F_OR:   r1 = Lbus | Rbus;
      F_XOR:  r1 = Lbus ^ Rbus;
      F_NOT:  r1 = ~Lbus;
      F_SHL, F_SHR, F_PASS: r1 = Lbus;
      default: r1 = '0;
    endcase
    multi = (FUNC == F_MUL) ||
            (((FUNC == F_SHL) || (FUNC == F_SHR)) && (Rbus[SHW-1:0] != '0));
  end

  // One iteration of the multi-cycle ops.
  logic [WIDTH-1:0] a_n, b_n, acc_n, rc;
  logic             c_n;

  always_comb begin
    a_n   = a;
    b_n   = b;
    acc_n = acc;
    c_n   = c;
    rc    = a;
    case (f)
      F_SHL: begin
        a_n = a << 1;
        c_n = a[WIDTH-1];
        rc  = a_n;
      end
      F_SHR: begin
        a_n = a >> 1;
        c_n = a[0];
        rc  = a_n;
      end
      default: begin
        acc_n = acc + (b[0] ? a : '0);
        a_n   = a << 1;
        b_n   = b >> 1;
        c_n   = 1'b0;
        rc    = acc_n;
      end
    endcase
  end

  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      f     <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      Obus  <= '0;
      FLAGS <= '0;
    end else begin
      case (state)
        IDLE: if (START) begin
          a   <= Lbus;
          b   <= Rbus;
          f   <= FUNC;
          acc <= '0;
          c   <= 1'b0;
          if (multi) begin
            cnt   <= (FUNC == F_MUL) ? (SHW+1)'(WIDTH) : {1'b0, Rbus[SHW-1:0]};
            state <= CALC;
          end else begin
            Obus  <= r1;
            FLAGS <= {r1 == '0, r1[WIDTH-1], c1, v1};
            state <= FIN;
          end
        end
        CALC: begin
          a   <= a_n;
          b   <= b_n;
          acc <= acc_n;
          c   <= c_n;
          cnt <= cnt - 1'b1;
          if (cnt == (SHW+1)'(1)) begin
            Obus  <= rc;
            FLAGS <= {rc == '0, rc[WIDTH-1], c_n, 1'b0};
            state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state == CALC);
  assign DONE = (state == FIN);
endmodule
